id_scan_arbiter: RTL and testbench
==================================

// Module: id_scan_arbiter
// PURPOSE
//   Shares one identifier recogniser among NUM_SRC independent character streams.
//   The recogniser classifies input as letter+ followed by digit+.
//   Per-source recogniser state (context) is kept in this block.
//   A round-robin arbiter grants one stream per cycle. The granted character advances
//   only that stream's context, and a registered per-character match result is emitted.
//   Sits between the character sources and the downstream token logic.
// PARAMETERS
//   NUM_SRC  4   number of requesting character streams (2..8)
//   SRC_W    2   width of source index, = clog2(NUM_SRC)
//   CNT_W    16  width of saturating match counter
// PORTS
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous, active-low reset
//   req_valid  in   NUM_SRC      stream i has a character pending
//   req_char   in   8*NUM_SRC    char of stream i at [8*i+7:8*i], ASCII
//   req_ready  out  NUM_SRC      one-hot grant; char i accepted when valid&ready
//   src_clear  in   NUM_SRC      force context of stream i to IDLE
//   out_valid  out  1            result valid (one cycle per accepted char)
//   out_src    out  SRC_W        stream index of the result
//   out_match  out  1            1 = stream is in DIG state after this char
//   match_cnt  out  CNT_W        total out_match pulses, saturating
// BEHAVIOUR
//   Classification (combinational on granted char):
//     DIGIT  = 0x30..0x39
//     LETTER = 0x41..0x5A or 0x61..0x7A
//     OTHER  = everything else
//   Context FSM per stream, 2 bits: IDLE=00, LET=01, DIG=10.
//     IDLE: LETTER->LET, else IDLE
//     LET:  LETTER->LET, DIGIT->DIG, OTHER->IDLE
//     DIG:  LETTER->LET, DIGIT->DIG, OTHER->IDLE
//     Code 11 is illegal: treated as IDLE and rewritten on next update.
//   Arbitration:
//     rr_ptr marks the highest-priority stream.
//     Search order: rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//     The first stream with req_valid=1 is granted.
//     req_ready is combinational from req_valid and rr_ptr; at most one bit is set.
//     No request -> req_ready=0, rr_ptr holds.
//     On grant g: rr_ptr <= (g+1) mod NUM_SRC. This is also the wrap at NUM_SRC-1.
//   Per cycle with grant g (one cycle of latency):
//     ctx[g] <= next state.
//     Next cycle: out_valid=1, out_src=g, out_match=(next==DIG).
//     No grant -> out_valid=0 next cycle; out_src and out_match hold their values.
//   Non-granted contexts hold, except when src_clear is asserted.
//   src_clear[i]:
//     ctx[i] <= IDLE next cycle.
//     If stream i is granted in the same cycle, clear wins:
//       the char is consumed (ready=1);
//       out_valid=1 with out_match=0;
//       ctx[i] becomes IDLE.
//     Clear does not affect arbitration.
//   match_cnt increments on every cycle with out_valid & out_match.
//     It holds at all ones (saturates), with no wrap.
//   Reset (async assert, sync-released use):
//     all ctx=IDLE, rr_ptr=0, out_valid=0, out_src=0, out_match=0, match_cnt=0.
//     req_ready=0 while rst_n=0.
//   Reset mid-stream drops any in-flight result. No output pulse is generated for it.
// TESTING
//   1 Single stream 0 sends "a","1","2",";" back-to-back.
//     -> out_match 0,1,1,0 on cycles 1..4; out_src=0; match_cnt=2.
//   2 All 4 valid every cycle from reset.
//     -> grants 0,1,2,3,0,...; req_ready one-hot each cycle.
//   3 Interleaving: s0 sends "x" then "9"; s1 sends "5" between them.
//     -> s0 result on "9" is match=1; s1 result is match=0. Contexts stay independent.
//   4 Streams 1 and 3 valid, rr_ptr=2.
//     -> grant 3, then 1, then 3. rr_ptr wraps 3->0.
//   5 s2 in DIG; src_clear[2] together with grant of "7".
//     -> out_match=0, ctx[2]=IDLE; next "7" gives match=0.
//   6 Force match_cnt to all-ones-1, then send 3 matches.
//     -> saturates at 0xFFFF.
//     Also: assert rst_n=0 mid-burst -> outputs and counter 0 immediately.

Source files
------------

// File: rtl/id_scan_arbiter.sv
// Shared letter+digit+ recogniser time-multiplexed over NUM_SRC streams.
// Ports: req_* in / req_ready out, src_clear, registered out_* result, match_cnt.
module id_scan_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   req_valid,
  input  logic [8*NUM_SRC-1:0] req_char,
  output logic [NUM_SRC-1:0]   req_ready,
  input  logic [NUM_SRC-1:0]   src_clear,
  output logic                 out_valid,
  output logic [SRC_W-1:0]     out_src,
  output logic                 out_match,
  output logic [CNT_W-1:0]     match_cnt
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LET  = 2'b01;
  localparam logic [1:0] S_DIG  = 2'b10;

  logic [1:0]         ctx [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;

  logic               gnt_any;
  logic [SRC_W-1:0]   gnt_idx;
  logic [NUM_SRC-1:0] gnt_oh;
  logic [7:0]         gnt_char;
  logic               is_dig;
  logic               is_let;
  logic [1:0]         cur;
  logic [1:0]         nxt;
  logic [1:0]         nxt_eff;
  logic [SRC_W-1:0]   rr_nxt;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    logic [SRC_W-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    gnt_oh[gnt_idx] = gnt_any;
  end

  assign req_ready = rst_n ? gnt_oh : '0;

  assign gnt_char = req_char[8*gnt_idx +: 8];

  always_comb begin
    is_dig = (gnt_char >= 8'h30) && (gnt_char <= 8'h39);
    is_let = ((gnt_char >= 8'h41) && (gnt_char <= 8'h5A)) ||
             ((gnt_char >= 8'h61) && (gnt_char <= 8'h7A));
  end

  // Code 11 is folded to IDLE so a corrupted context self-heals.
  always_comb begin
    cur = ctx[gnt_idx];
    if (cur == 2'b11) cur = S_IDLE;
    nxt = S_IDLE;
    unique case (1'b1)
      is_let:  nxt = S_LET;
      is_dig:  nxt = (cur == S_IDLE) ? S_IDLE : S_DIG;
      default: nxt = S_IDLE;
    endcase
    nxt_eff = src_clear[gnt_idx] ? S_IDLE : nxt;
  end

  assign rr_nxt = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0
                                                   : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) ctx[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_clear[i])   ctx[i] <= S_IDLE;
        else if (gnt_oh[i]) ctx[i] <= nxt_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      out_match <= 1'b0;
    end else begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        rr_ptr    <= rr_nxt;
        out_src   <= gnt_idx;
        out_match <= (nxt_eff == S_DIG);
      end
    end
  end

  // Counts emitted match pulses; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (out_valid && out_match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_scan_arbiter.sv
// Directed bench for id_scan_arbiter: vector tables plus
// hand sequences for reset, clear and counter saturation.
module tb_id_scan_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_char;
  logic [3:0]  req_ready;
  logic [3:0]  src_clear;
  logic        out_valid;
  logic [1:0]  out_src;
  logic        out_match;
  logic [15:0] match_cnt;

  id_scan_arbiter #(.NUM_SRC(4), .SRC_W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_char  (req_char),
    .req_ready (req_ready),
    .src_clear (src_clear),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_match (out_match),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string      nm;
    logic [3:0]  v;
    logic [31:0] ch;
    logic [3:0]  clr;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  src;
    logic        m;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] v,
                              input logic [31:0] ch, input logic [3:0] clr,
                              input logic [3:0] rdy, input logic ov,
                              input logic [1:0] src, input logic m);
    vec_t r;
    r.nm = nm; r.v = v; r.ch = ch; r.clr = clr;
    r.rdy = rdy; r.ov = ov; r.src = src; r.m = m;
    return r;
  endfunction

  task automatic run_tbl();
    foreach (tbl[i]) begin
      @(negedge clk);
      req_valid = tbl[i].v;
      req_char  = tbl[i].ch;
      src_clear = tbl[i].clr;
      #1;
      chk({tbl[i].nm, ".rdy"}, 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk({tbl[i].nm, ".ov"}, 32'(out_valid), 32'(tbl[i].ov));
      chk({tbl[i].nm, ".src"}, 32'(out_src), 32'(tbl[i].src));
      chk({tbl[i].nm, ".m"}, 32'(out_match), 32'(tbl[i].m));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    src_clear = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive0(input logic [7:0] c);
    @(negedge clk);
    req_valid = 4'b0001;
    req_char  = {24'h0, c};
    src_clear = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = '0;
      src_clear = '0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_char  = '0;
    src_clear = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 32'(req_ready), 0);
    chk("rst.ov", 32'(out_valid), 0);
    chk("rst.src", 32'(out_src), 0);
    chk("rst.m", 32'(out_match), 0);
    chk("rst.cnt", 32'(match_cnt), 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // single stream "a12;"
    tbl.push_back(mk("t1a", 4'b0001, {24'h0, "a"}, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk("t1b", 4'b0001, {24'h0, "1"}, 0, 4'b0001, 1, 0, 1));
    tbl.push_back(mk("t1c", 4'b0001, {24'h0, "2"}, 0, 4'b0001, 1, 0, 1));
    tbl.push_back(mk("t1d", 4'b0001, {24'h0, ";"}, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk("t1e", 4'b0000, {24'h0, ";"}, 0, 4'b0000, 0, 0, 0));
    run_tbl();
    idle(1);
    @(posedge clk); #1;
    chk("t1.cnt", 32'(match_cnt), 2);

    // all streams valid: plain rotation
    do_reset();
    tbl.push_back(mk("t2a", 4'hF, "aaaa", 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk("t2b", 4'hF, "aaaa", 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("t2c", 4'hF, "aaaa", 0, 4'b0100, 1, 2, 0));
    tbl.push_back(mk("t2d", 4'hF, "aaaa", 0, 4'b1000, 1, 3, 0));
    tbl.push_back(mk("t2e", 4'hF, "1111", 0, 4'b0001, 1, 0, 1));
    tbl.push_back(mk("t2f", 4'hF, "1111", 0, 4'b0010, 1, 1, 1));
    run_tbl();

    // interleaved streams keep separate context
    do_reset();
    tbl.push_back(mk("t3a", 4'b0001, {24'h0, "x"}, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk("t3b", 4'b0010, {16'h0, "5", 8'h0}, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("t3c", 4'b0001, {24'h0, "9"}, 0, 4'b0001, 1, 0, 1));
    run_tbl();

    // streams 1 and 3 from rr_ptr=2, wrap to 0
    do_reset();
    tbl.push_back(mk("t4a", 4'b0010, {16'h0, "b", 8'h0}, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("t4b", 4'b1010, {"d", 8'h0, "c", 8'h0}, 0, 4'b1000, 1, 3, 0));
    tbl.push_back(mk("t4c", 4'b1010, {"4", 8'h0, "c", 8'h0}, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("t4d", 4'b1010, {"4", 8'h0, "c", 8'h0}, 0, 4'b1000, 1, 3, 1));
    tbl.push_back(mk("t4e", 4'b1001, {"5", 16'h0, "z"}, 0, 4'b0001, 1, 0, 0));
    run_tbl();

    // clear on stream 2, with and without a same-cycle grant
    do_reset();
    tbl.push_back(mk("t5a", 4'b0100, {8'h0, "q", 16'h0}, 0, 4'b0100, 1, 2, 0));
    tbl.push_back(mk("t5b", 4'b0100, {8'h0, "3", 16'h0}, 0, 4'b0100, 1, 2, 1));
    tbl.push_back(mk("t5c", 4'b0100, {8'h0, "7", 16'h0}, 4'b0100, 4'b0100, 1, 2, 0));
    tbl.push_back(mk("t5d", 4'b0100, {8'h0, "7", 16'h0}, 0, 4'b0100, 1, 2, 0));
    tbl.push_back(mk("t5e", 4'b0100, {8'h0, "k", 16'h0}, 0, 4'b0100, 1, 2, 0));
    tbl.push_back(mk("t5f", 4'b0000, {8'h0, "k", 16'h0}, 4'b0100, 4'b0000, 0, 2, 0));
    tbl.push_back(mk("t5g", 4'b0100, {8'h0, "8", 16'h0}, 0, 4'b0100, 1, 2, 0));
    run_tbl();

    // counter saturation
    do_reset();
    drive0("a");
    for (int i = 0; i < 65534; i++) drive0("1");
    idle(2);
    @(posedge clk); #1;
    chk("t6.pre", 32'(match_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) drive0("2");
    idle(2);
    @(posedge clk); #1;
    chk("t6.sat", 32'(match_cnt), 32'hFFFF);

    // reset mid-burst
    drive0("3");
    drive0("4");
    @(posedge clk); #3;
    chk("t6.pre_ov", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_ov", 32'(out_valid), 0);
    chk("t6.rst_m", 32'(out_match), 0);
    chk("t6.rst_cnt", 32'(match_cnt), 0);
    chk("t6.rst_rdy", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6.drop", 32'(out_valid), 0);
    tbl.push_back(mk("t6r", 4'b0001, {24'h0, "5"}, 0, 4'b0001, 1, 0, 0));
    run_tbl();
    idle(1);
    @(posedge clk); #1;
    chk("t6.cnt0", 32'(match_cnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
